// File: rtl/mem_bridge.sv
// rtl/mem_bridge.sv - byte-bus to 16-bit async SRAM bridge with one-word read buffer
module mem_bridge #(
  parameter int ADR_MSB     = 15,
  parameter int WAIT_STATES = 2,
  parameter int WS_W        = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m_cs,
  input  logic               m_we,
  input  logic [ADR_MSB:0]   m_addr,
  input  logic [7:0]         m_odata,
  output logic [7:0]         m_idata,
  output logic               m_wait,
  input  logic               inv,
  output logic [ADR_MSB-1:0] x_addr,
  output logic [15:0]        x_wdata,
  input  logic [15:0]        x_rdata,
  output logic [1:0]         x_be,
  output logic               x_oe,
  output logic               x_we
);

  localparam int WS_EFF = (WAIT_STATES == 0) ? 1 : WAIT_STATES;
  localparam logic [WS_W-1:0] CNT_LOAD = WS_W'(WS_EFF - 1);
  localparam logic [WS_W-1:0] CNT_ONE  = WS_W'(1);

  typedef enum logic [1:0] {IDLE, RD, WR, WACK} state_t;

  state_t             state, state_nxt;
  logic               buf_valid;
  logic [ADR_MSB-1:0] buf_tag;
  logic [15:0]        buf_data;
  logic [WS_W-1:0]    cnt;
  logic               hit;
  logic               start_rd, start_wr;
  logic               cnt_done;

  assign hit      = buf_valid && (buf_tag == m_addr[ADR_MSB:1]);
  assign cnt_done = (cnt == '0);
  assign m_idata  = m_addr[0] ? buf_data[15:8] : buf_data[7:0];
  assign m_wait   = m_cs && !((!m_we && hit && state == IDLE) || state == WACK);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_rd  = 1'b0;
    start_wr  = 1'b0;
    case (state)
      IDLE: begin
        if (m_cs && m_we) begin
          start_wr  = 1'b1;
          state_nxt = WR;
        end else if (m_cs && !hit) begin
          start_rd  = 1'b1;
          state_nxt = RD;
        end
      end
      RD:      if (cnt_done) state_nxt = IDLE;
      WR:      if (cnt_done) state_nxt = WACK;
      WACK:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
      cnt       <= '0;
      x_oe      <= 1'b0;
      x_we      <= 1'b0;
      x_be      <= 2'b00;
      x_addr    <= '0;
      x_wdata   <= '0;
    end else begin
      if (start_rd) begin
        x_addr <= m_addr[ADR_MSB:1];
        x_oe   <= 1'b1;
        x_be   <= 2'b11;
        cnt    <= CNT_LOAD;
      end else if (start_wr) begin
        x_addr  <= m_addr[ADR_MSB:1];
        x_wdata <= {m_odata, m_odata};
        x_be    <= m_addr[0] ? 2'b10 : 2'b01;
        x_we    <= 1'b1;
        cnt     <= CNT_LOAD;
      end else if (state == RD || state == WR) begin
        if (!cnt_done) begin
          cnt <= cnt - CNT_ONE;
        end else begin
          x_oe <= 1'b0;
          x_we <= 1'b0;
          x_be <= 2'b00;
          if (state == RD) begin
            buf_data  <= x_rdata;
            buf_tag   <= x_addr;
            buf_valid <= 1'b1;
          end else if (buf_valid && buf_tag == x_addr) begin
            // keep the buffered word coherent with the write-through
            if (x_be[0]) buf_data[7:0]  <= x_wdata[7:0];
            if (x_be[1]) buf_data[15:8] <= x_wdata[15:8];
          end
        end
      end
      if (inv) buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// tb/tb_mem_bridge.sv - randomized self-checking bench for mem_bridge
module tb_mem_bridge;

  localparam int ADR_MSB     = 15;
  localparam int WAIT_STATES = 2;
  localparam int LAT         = WAIT_STATES + 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               m_cs, m_we, inv;
  logic [ADR_MSB:0]   m_addr;
  logic [7:0]         m_odata, m_idata;
  logic               m_wait;
  logic [ADR_MSB-1:0] x_addr;
  logic [15:0]        x_wdata, x_rdata;
  logic [1:0]         x_be;
  logic               x_oe, x_we;

  mem_bridge #(.ADR_MSB(ADR_MSB), .WAIT_STATES(WAIT_STATES), .WS_W(3)) dut (
    .clk(clk), .rst(rst), .m_cs(m_cs), .m_we(m_we), .m_addr(m_addr),
    .m_odata(m_odata), .m_idata(m_idata), .m_wait(m_wait), .inv(inv),
    .x_addr(x_addr), .x_wdata(x_wdata), .x_rdata(x_rdata), .x_be(x_be),
    .x_oe(x_oe), .x_we(x_we)
  );

  always #5 clk = ~clk;

  logic [15:0] sram    [0:32767];
  logic [7:0]  mem_ref [0:65535];
  bit          ref_valid;
  logic [14:0] ref_tag;

  assign x_rdata = sram[x_addr];

  int          oe_cnt, we_cnt;
  logic [1:0]  last_be;
  logic [15:0] last_wd;

  always @(posedge clk) begin
    if (x_oe) oe_cnt <= oe_cnt + 1;
    if (x_we) begin
      we_cnt  <= we_cnt + 1;
      last_be <= x_be;
      last_wd <= x_wdata;
      if (x_be[0]) sram[x_addr][7:0]  <= x_wdata[7:0];
      if (x_be[1]) sram[x_addr][15:8] <= x_wdata[15:8];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One core access; inv_at >= 0 pulses inv in that wait cycle of the access.
  task automatic op(input bit we, input logic [15:0] addr, input logic [7:0] wd, input int inv_at);
    bit         hit, done;
    int         exp_w, waits;
    logic [7:0] rd;
    hit   = ref_valid && (ref_tag == addr[15:1]);
    exp_w = (we || !hit) ? LAT : 0;
    if (!we && !hit && inv_at == LAT - 1) exp_w += LAT;
    oe_cnt = 0;
    we_cnt = 0;
    m_cs = 1'b1; m_we = we; m_addr = addr; m_odata = wd;
    waits = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (waits == inv_at) inv = 1'b1;
      if (!m_wait) begin
        done = 1'b1;
      end else begin
        waits++;
        if (waits > 40) begin
          check("timeout", waits, 0);
          done = 1'b1;
        end else begin
          @(posedge clk);
          #1 inv = 1'b0;
        end
      end
    end
    rd = m_idata;
    @(posedge clk);
    #1;
    inv  = 1'b0;
    m_cs = 1'b0;
    check(we ? "wr_wait" : "rd_wait", waits, exp_w);
    if (we) begin
      check("wr_strobe", we_cnt, WAIT_STATES);
      check("wr_be", last_be, addr[0] ? 2'b10 : 2'b01);
      check("wr_data", last_wd, {wd, wd});
      mem_ref[addr] = wd;
    end else begin
      check("rd_data", rd, mem_ref[addr]);
      check("rd_strobe", oe_cnt, (exp_w / LAT) * WAIT_STATES);
      ref_valid = !(hit && inv_at == 0);
      ref_tag   = addr[15:1];
    end
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
      if (i == 1) w = 16'hBEEF;
      sram[i]          = w;
      mem_ref[2*i]     = w[7:0];
      mem_ref[2*i + 1] = w[15:8];
    end
    ref_valid = 1'b0;
    ref_tag   = '0;
    inv = 1'b0; m_we = 1'b0; m_addr = '0; m_odata = '0;

    rst  = 1'b0;
    m_cs = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_oe", x_oe, 1'b0);
    check("rst_we", x_we, 1'b0);
    check("rst_be", x_be, 2'b00);
    check("rst_wait", m_wait, 1'b1);
    check("rst_addr", x_addr, 15'h0);
    @(posedge clk);
    #1 m_cs = 1'b0; rst = 1'b1;

    op(1'b0, 16'h0000, 8'h00, -1);
    op(1'b0, 16'h0002, 8'h00, -1);
    check("beef_lo", mem_ref[16'h0002], 8'hEF);
    op(1'b0, 16'h0003, 8'h00, -1);
    op(1'b1, 16'h0003, 8'h5A, -1);
    op(1'b0, 16'h0003, 8'h00, -1);
    op(1'b1, 16'h0010, 8'hC3, -1);
    op(1'b0, 16'h0002, 8'h00, -1);
    op(1'b0, 16'h0100, 8'h00, LAT - 1);
    op(1'b0, 16'h0101, 8'h00, 0);
    op(1'b0, 16'h0100, 8'h00, -1);

    we_cnt = 0;
    m_cs = 1'b1; m_we = 1'b1; m_addr = 16'h0020; m_odata = 8'h11;
    @(posedge clk);
    #1 m_cs = 1'b0;
    @(negedge clk);
    check("drop_nowait", m_wait, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("drop_strobe", we_cnt, WAIT_STATES);
    check("drop_sram", sram[15'h0010][7:0], 8'h11);
    mem_ref[16'h0020] = 8'h11;
    op(1'b0, 16'h0020, 8'h00, -1);

    m_cs = 1'b1; m_we = 1'b1; m_addr = 16'h0030; m_odata = 8'h77;
    @(posedge clk);
    #1;
    check("arst_started", x_we, 1'b1);
    rst = 1'b0;
    #1;
    check("arst_we", x_we, 1'b0);
    check("arst_be", x_be, 2'b00);
    check("arst_wait", m_wait, 1'b1);
    m_cs = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    ref_valid = 1'b0;
    op(1'b0, 16'h0030, 8'h00, -1);

    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) a = 16'($urandom);
      op(1'($urandom_range(0, 2) == 0), a, 8'($urandom), -1);
      if ($urandom_range(0, 7) == 0) begin
        inv = 1'b1;
        @(posedge clk);
        #1 inv = 1'b0;
        ref_valid = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
